// File: rtl/cp_mod_counter.sv
// Up/down counter with a programmable terminal value, wrap or saturate mode,
// synchronous load/clear and a combinational carry-out for cascading stages.
module cp_mod_counter #(
    parameter int N    = 6,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         clear,
    input  logic [N-1:0] limit,
    input  logic         sat,
    output logic [N-1:0] value,
    output logic         co,
    output logic         at_limit,
    output logic         wrap,
    output logic         sat_flag
);

    localparam logic [N-1:0] INIT_V = N'(INIT);
    localparam logic [N-1:0] ZERO_V = {N{1'b0}};
    localparam logic [N-1:0] ONE_V  = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] value_q, value_d;
    logic         wrap_q, wrap_d;
    logic         sat_flag_q, sat_flag_d;
    logic         up_s, down_s;

    assign up_s   = en & inc & ~dec;
    assign down_s = en & dec & ~inc;

    // Next-state selection: clear, then load, then a single count step.
    always_comb begin
        value_d    = value_q;
        wrap_d     = 1'b0;
        sat_flag_d = sat_flag_q;
        if (clear) begin
            value_d    = INIT_V;
            sat_flag_d = 1'b0;
        end else if (load) begin
            value_d = (load_data > limit) ? limit : load_data;
        end else if (up_s) begin
            // >= rather than == so a value stranded above a lowered limit still terminates
            if (value_q < limit) begin
                value_d = value_q + ONE_V;
            end else if (!sat) begin
                value_d = ZERO_V;
                wrap_d  = 1'b1;
            end else begin
                value_d    = limit;
                sat_flag_d = 1'b1;
            end
        end else if (down_s) begin
            if (value_q > limit) begin
                value_d = limit;
            end else if (value_q != ZERO_V) begin
                value_d = value_q - ONE_V;
            end else if (!sat) begin
                value_d = limit;
                wrap_d  = 1'b1;
            end else begin
                value_d    = ZERO_V;
                sat_flag_d = 1'b1;
            end
        end else begin
            value_d = value_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            value_q    <= INIT_V;
            wrap_q     <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            wrap_q     <= wrap_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    // Carry is raised in the same cycle as the terminal count so the next stage steps on the same edge.
    assign co = ~load & ~clear &
                ((up_s & (value_q >= limit)) | (down_s & (value_q == ZERO_V)));

    assign at_limit = (value_q == limit);
    assign value    = value_q;
    assign wrap     = wrap_q;
    assign sat_flag = sat_flag_q;

endmodule

// File: tb/tb_cp_mod_counter.sv
// Randomised scoreboard bench for cp_mod_counter plus a two-stage cascade check.
module tb_cp_mod_counter;

    localparam int N = 6;
    localparam int INIT = 0;

    logic         clk = 1'b0;
    logic         reset, en, inc, dec, load, clear, sat;
    logic [N-1:0] load_data, limit;
    logic [N-1:0] value;
    logic         co, at_limit, wrap, sat_flag;

    logic         cas_reset, cas_run;
    logic [N-1:0] lo_value, hi_value;
    logic         lo_co, hi_co, lo_at, hi_at, lo_wrap, hi_wrap, lo_sf, hi_sf;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit      chk_comb;
        bit      exp_co;
        bit      exp_at;
        int      exp_value;
        bit      exp_wrap;
        bit      exp_sat;
    } exp_t;

    exp_t sb_q[$];

    // Reference state: plain integers following the behavioural rules.
    int m_value = 0;
    bit m_wrap = 1'b0;
    bit m_sat = 1'b0;

    always #5 clk = ~clk;

    cp_mod_counter #(.N(N), .INIT(INIT)) dut (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
        .load_data(load_data), .clear(clear), .limit(limit), .sat(sat),
        .value(value), .co(co), .at_limit(at_limit), .wrap(wrap), .sat_flag(sat_flag)
    );

    cp_mod_counter #(.N(N), .INIT(0)) u_lo (
        .clk(clk), .reset(cas_reset), .en(1'b1), .inc(cas_run), .dec(1'b0), .load(1'b0),
        .load_data(6'd0), .clear(1'b0), .limit(6'd2), .sat(1'b0),
        .value(lo_value), .co(lo_co), .at_limit(lo_at), .wrap(lo_wrap), .sat_flag(lo_sf)
    );

    cp_mod_counter #(.N(N), .INIT(0)) u_hi (
        .clk(clk), .reset(cas_reset), .en(lo_co), .inc(1'b1), .dec(1'b0), .load(1'b0),
        .load_data(6'd0), .clear(1'b0), .limit(6'd2), .sat(1'b0),
        .value(hi_value), .co(hi_co), .at_limit(hi_at), .wrap(hi_wrap), .sat_flag(hi_sf)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus and push the expected response.
    task automatic step(input bit r, input bit c, input bit l, input bit e, input bit i,
                        input bit d, input bit s, input int ld, input int lim);
        exp_t x;
        bit up, down;
        @(posedge clk);
        #2;
        reset = r; clear = c; load = l; en = e; inc = i; dec = d; sat = s;
        load_data = N'(ld); limit = N'(lim);
        up   = e && i && !d;
        down = e && d && !i;
        x.chk_comb = r;
        x.exp_co   = !l && !c && ((up && m_value >= lim) || (down && m_value == 0));
        x.exp_at   = (m_value == lim);
        if (!r || c) begin
            m_value = INIT; m_wrap = 1'b0; m_sat = 1'b0;
        end else if (l) begin
            m_value = (ld < lim) ? ld : lim; m_wrap = 1'b0;
        end else if (up) begin
            m_wrap = 1'b0;
            if (m_value < lim) m_value = m_value + 1;
            else if (!s) begin m_value = 0; m_wrap = 1'b1; end
            else begin m_value = lim; m_sat = 1'b1; end
        end else if (down) begin
            m_wrap = 1'b0;
            if (m_value > lim) m_value = lim;
            else if (m_value > 0) m_value = m_value - 1;
            else if (!s) begin m_value = lim; m_wrap = 1'b1; end
            else m_sat = 1'b1;
        end else begin
            m_wrap = 1'b0;
        end
        x.exp_value = m_value;
        x.exp_wrap  = m_wrap;
        x.exp_sat   = m_sat;
        sb_q.push_back(x);
    endtask

    // Monitor: combinational outputs before the edge, registered ones just after it.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                if (x.chk_comb) begin
                    chk("co", int'(co), int'(x.exp_co));
                    chk("at_limit", int'(at_limit), int'(x.exp_at));
                end
                @(posedge clk);
                #1;
                chk("value", int'(value), x.exp_value);
                chk("wrap", int'(wrap), int'(x.exp_wrap));
                chk("sat_flag", int'(sat_flag), int'(x.exp_sat));
            end
        end
    end

    initial begin
        int lim, ld, k;
        bit s;
        reset = 1'b0; clear = 1'b0; load = 1'b0; en = 1'b0; inc = 1'b0; dec = 1'b0;
        sat = 1'b0; load_data = '0; limit = '0; cas_reset = 1'b0; cas_run = 1'b0;

        // Reset overrides inc and load, then count freely
        step(0, 0, 1, 1, 1, 0, 0, 5, 63);
        step(0, 0, 1, 1, 1, 0, 0, 5, 63);
        repeat (3) step(1, 0, 0, 1, 1, 0, 0, 0, 63);
        // Wrap up with limit 4
        step(1, 1, 0, 0, 0, 0, 0, 0, 4);
        repeat (5) step(1, 0, 0, 1, 1, 0, 0, 0, 4);
        // Wrap down, then saturate at 0 and hold the sticky flag until clear
        step(1, 0, 0, 1, 0, 1, 0, 0, 4);
        step(1, 1, 0, 0, 0, 0, 0, 0, 4);
        step(1, 0, 0, 1, 0, 1, 1, 0, 4);
        step(1, 0, 0, 1, 1, 0, 1, 0, 4);
        step(1, 1, 0, 0, 0, 0, 1, 0, 4);
        // Load clamp, clear beats load, inc+dec holds
        step(1, 0, 1, 1, 1, 0, 0, 20, 10);
        step(1, 1, 1, 1, 1, 0, 0, 20, 10);
        step(1, 0, 1, 0, 0, 0, 0, 7, 10);
        step(1, 0, 0, 1, 1, 1, 0, 0, 10);
        // Lowered limit with up/wrap, up/sat, down/clamp
        step(1, 0, 1, 0, 0, 0, 0, 9, 10);
        step(1, 0, 0, 1, 1, 0, 0, 0, 5);
        step(1, 0, 1, 0, 0, 0, 0, 9, 10);
        step(1, 0, 0, 1, 1, 0, 1, 0, 5);
        step(1, 0, 1, 0, 0, 0, 0, 9, 10);
        step(1, 0, 0, 1, 0, 1, 0, 0, 5);
        // Degenerate limit 0
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0, 0);

        lim = 7; s = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) == 0)
                lim = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 15);
            if ($urandom_range(0, 19) == 0) s = ~s;
            ld = $urandom_range(0, 63);
            step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 1), $urandom_range(0, 2) == 0, s, ld, lim);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        // Cascade: {hi,lo} counts base 3, hi wraps on the ninth count
        @(posedge clk); #2;
        cas_reset = 1'b1; cas_run = 1'b1;
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk("cascade_lo", int'(lo_value), k % 3);
            chk("cascade_hi", int'(hi_value), (k / 3) % 3);
            chk("cascade_hi_wrap", int'(hi_wrap), (k % 9 == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cp_mod_counter.md
Name: cp_mod_counter

Overview:
Parametrised up/down counter for the column-parity datapath, with a runtime-programmable terminal value (modulus), wrap or saturate mode, and synchronous load/clear. It drives row/column/round indices, where lane and round loops need limits other than 2^N. A combinational carry-out (co) lets instances cascade into multi-digit index counters. Registered wrap and saturation flags report loop completion to the controller.

Parameters:
N, 6, counter width in bits
INIT, 0, value loaded on reset and clear; must be <= any limit used

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
en  input  1  count enable; gates inc/dec and co, not load/clear
inc  input  1  count up by 1
dec  input  1  count down by 1
load  input  1  synchronous load of load_data
load_data  input  N  value to load
clear  input  1  synchronous return to INIT
limit  input  N  terminal value; count range is 0..limit
sat  input  1  mode: 1 = saturate at the ends, 0 = wrap
value  output  N  registered count
co  output  1  combinational carry/borrow out for cascading
at_limit  output  1  combinational, value == limit
wrap  output  1  registered one-cycle pulse, set when a wrap occurred last cycle
sat_flag  output  1  registered sticky flag, set when a count was blocked by saturation

Behaviour:
- Everything is sampled on the rising edge of clk. Reset is synchronous: reset=0 at an edge sets value=INIT, wrap=0, sat_flag=0, and overrides all other inputs.
- Priority, highest first: reset, clear, load, count.
- clear: value=INIT, wrap=0, sat_flag=0.
- load:
  - value = min(load_data, limit); wrap=0; sat_flag unchanged.
  - load is honoured regardless of en.
- Count direction:
  - up = en & inc & ~dec; down = en & dec & ~inc.
  - inc and dec both high, or en low: value holds and wrap=0.
- Up count:
  - value < limit: value+1.
  - value >= limit, sat=0: value=0 and wrap=1 for one cycle.
  - value >= limit, sat=1: value=limit and sat_flag=1.
- Down count:
  - value > limit: value=limit. This is a clamp, not a wrap.
  - 0 < value <= limit: value-1.
  - value == 0, sat=0: value=limit and wrap=1.
  - value == 0, sat=1: value holds at 0 and sat_flag=1.
- wrap is 0 on every cycle that does not wrap. sat_flag clears only on reset or clear.
- co = up & (value >= limit) | down & (value == 0). It is asserted in the same cycle as the count that wraps, so the next cascade stage counts on the same edge. co is independent of sat and is 0 while load or clear is high.
- at_limit reflects the current registered value only.
- limit may change at any time; it takes effect at the next edge. The >= compares cover a value left above a newly lowered limit.
- limit=0 is a degenerate range: value stays 0. Each up or down count with sat=0 pulses wrap and asserts co.
- Arithmetic is N-bit unsigned. No intermediate result wider than N+1 bits is needed; no overflow is possible beyond the rules above.
- Single-cycle latency for all operations; no internal state beyond value, wrap and sat_flag.

Test Plan:
- Reset: N=6, INIT=0, reset=0 for 2 cycles with inc=1, load=1 -> value=0, wrap=0, sat_flag=0; after release with limit=63, inc=1, en=1, 3 cycles -> value=3.
- Wrap up: limit=4, sat=0, inc=1 from 0 for 5 cycles -> value 1,2,3,4,0; co=1 in the cycle value=4; wrap=1 only in the cycle after value becomes 0.
- Wrap down and saturate: limit=4, sat=0, dec from 0 -> value=4 with wrap pulse. With sat=1, dec from 0 -> value stays 0 and sat_flag=1 until clear.
- Load clamp and priority: limit=10, load_data=20, load=1, inc=1 -> value=10. clear=1 together with load=1 -> value=INIT. inc=dec=1 -> value holds.
- Limit lowered mid-count: value=9, limit changed to 5, inc with sat=0 -> value=0 with wrap=1. Same with sat=1 -> value=5 with sat_flag=1. Same with dec -> value=5.
- Cascade: two instances, low stage co driving the high stage en, both limit=2, sat=0 -> {high,low} steps 00,01,02,10,...,22,00. The high stage wrap pulses after 9 counts.
